// File: rtl/uart_tx_responder.sv
// UART transmitter with a register front end and TX FIFO.
// Define UART_TX_DIVISOR_REG_EN to make the DIVISOR register writable.
module uart_tx_responder #(
  parameter int CLOCKS_PER_BIT  = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        reset_n,
  input  logic        clk,
  output logic        ready,
  input  logic [3:0]  addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_enable,
  input  logic        write_req,
  input  logic        read_req,
  output logic [31:0] read_data,
  output logic        read_data_valid,
  output logic        tx
);
  localparam int AW = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [15:0] DIV_RST = 16'(CLOCKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [15:0]   div_q;
  logic [15:0]   fdiv_q, fdiv_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q;
  logic [31:0]   status, div_rd;
  logic [4:0]    fill5;
  logic          full, empty, busy;
  logic          wr_acc, rd_acc, push, pop, bit_end;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign ready   = ~full;
  assign wr_acc  = write_req & ready;
  assign rd_acc  = read_req & ready;
  assign push    = wr_acc & (addr[3:2] == 2'd0) & byte_enable[0];
  assign bit_end = baud_q == fdiv_q - 16'd1;
  assign busy    = ~empty | (state_q != IDLE);
  assign fill5   = 5'(cnt_q);
  assign status  = {19'b0, fill5, 6'b0, full, busy};

`ifdef UART_TX_DIVISOR_REG_EN
  logic [15:0] div_d;
  logic        unused;
  assign unused = ^{write_data[31:16], byte_enable[3:2], addr[1:0]};

  always_comb begin
    div_d = div_q;
    if (wr_acc && addr[3:2] == 2'd2) begin
      if (byte_enable[0]) div_d[7:0] = write_data[7:0];
      if (byte_enable[1]) div_d[15:8] = write_data[15:8];
      if (div_d < 16'd2) div_d = 16'd2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_q <= DIV_RST;
    else          div_q <= div_d;
  end

  assign div_rd = {16'b0, div_q};
`else
  logic unused;
  assign unused = ^{write_data[31:8], byte_enable[3:1], addr[1:0]};
  assign div_q  = DIV_RST;
  assign div_rd = '0;
`endif

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      addr[3:2] == 2'd1: rdata_d = status;
      addr[3:2] == 2'd2: rdata_d = div_rd;
      default:           rdata_d = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    fdiv_d  = fdiv_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          fdiv_d  = div_q;
          baud_d  = '0;
          shift_d = mem_q[rptr_q];
          tx_d    = 1'b0;
        end
      end
      START: begin
        baud_d = baud_q + 16'd1;
        if (bit_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        baud_d = baud_q + 16'd1;
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        baud_d = baud_q + 16'd1;
        if (bit_end) begin
          baud_d = '0;
          // Next frame starts on the very next cycle: no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
            fdiv_d  = div_q;
            shift_d = mem_q[rptr_q];
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= write_data[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      fdiv_q   <= DIV_RST;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q    <= cnt_d;
      fdiv_q   <= fdiv_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rdata_q  <= rd_acc ? rdata_d : '0;
      rvalid_q <= rd_acc;
    end
  end

  assign read_data       = rdata_q;
  assign read_data_valid = rvalid_q;
  assign tx              = tx_q;

endmodule

// File: tb/tb_uart_tx_responder.sv
// Bench for uart_tx_responder: byte scoreboard checked by a serial
// line monitor, plus per-feature register and timing checks.
module tb_uart_tx_responder;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ready;
  logic [3:0]  addr = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  byte_enable = '0;
  logic        write_req = 1'b0;
  logic        read_req = 1'b0;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        tx;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int mdiv = CPB;
  logic [7:0] sb[$];
  int starts[$];
  logic mon_busy = 1'b0;
  logic mon_abort = 1'b0;

  uart_tx_responder #(
    .CLOCKS_PER_BIT(CPB),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .reset_n(reset_n),
    .clk(clk),
    .ready(ready),
    .addr(addr),
    .write_data(write_data),
    .byte_enable(byte_enable),
    .write_req(write_req),
    .read_req(read_req),
    .read_data(read_data),
    .read_data_valid(read_data_valid),
    .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial monitor: decodes each frame and compares to the scoreboard.
  always begin : monitor
    logic [7:0] exp, got;
    logic have, ok, aborted, e;
    int fdiv, b;
    @(negedge clk);
    if (!mon_abort && reset_n === 1'b1 && tx === 1'b0) begin
      mon_busy = 1'b1;
      fdiv = mdiv;
      starts.push_back(cyc);
      have = sb.size() > 0;
      exp = 8'h00;
      got = 8'h00;
      if (have) exp = sb.pop_front();
      ok = 1'b1;
      aborted = 1'b0;
      for (int k = 0; k < 10 * fdiv; k++) begin
        if (k != 0) @(negedge clk);
        if (mon_abort) begin
          aborted = 1'b1;
          break;
        end
        b = k / fdiv;
        if (b == 0) e = 1'b0;
        else if (b == 9) e = 1'b1;
        else begin
          e = exp[b-1];
          got[b-1] = tx;
        end
        if (tx !== e) ok = 1'b0;
      end
      if (!aborted) begin
        vecs++;
        if (!have || !ok) begin
          errs++;
          $display("FAIL frame: got=%02h exp=%02h expected_frame=%0d bit_timing_ok=%0d",
                   got, exp, have, ok);
        end
      end
      mon_busy = 1'b0;
    end
  end

  task automatic model_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] be);
`ifdef UART_TX_DIVISOR_REG_EN
    logic [15:0] nd;
`endif
    if (a[3:2] == 2'd0 && be[0]) sb.push_back(d[7:0]);
`ifdef UART_TX_DIVISOR_REG_EN
    if (a[3:2] == 2'd2) begin
      nd = 16'(mdiv);
      if (be[0]) nd[7:0] = d[7:0];
      if (be[1]) nd[15:8] = d[15:8];
      if (nd < 16'd2) nd = 16'd2;
      mdiv = int'(nd);
    end
`endif
  endtask

  task automatic wait_ready(output logic ok);
    int n = 0;
    while (ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 1000);
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL ready_timeout: ready=%b required 1", ready);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    logic ok;
    addr = a;
    write_data = d;
    byte_enable = be;
    write_req = 1'b1;
    wait_ready(ok);
    if (ok) model_write(a, d, be);
    @(negedge clk);
    write_req = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic v,
                          output logic [31:0] d);
    logic ok;
    addr = a;
    read_req = 1'b1;
    wait_ready(ok);
    @(negedge clk);
    read_req = 1'b0;
    v = read_data_valid;
    d = read_data;
  endtask

  task automatic bus_rw(input logic [3:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic v,
                        output logic [31:0] d);
    logic ok;
    addr = a;
    write_data = wd;
    byte_enable = be;
    write_req = 1'b1;
    read_req = 1'b1;
    wait_ready(ok);
    if (ok) model_write(a, wd, be);
    @(negedge clk);
    write_req = 1'b0;
    read_req = 1'b0;
    v = read_data_valid;
    d = read_data;
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((sb.size() != 0 || mon_busy || tx !== 1'b1) && n < 3000);
    vecs++;
    if (n >= 3000) begin
      errs++;
      $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic v;
    logic [31:0] d, exp;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({tx, ready, read_data_valid} !== 3'b110 || read_data !== 32'h0) begin
      errs++;
      $display("FAIL reset_outputs: tx/ready/rdv=%b rd=%h required 110/0",
               {tx, ready, read_data_valid}, read_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(4'h4, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errs++;
      $display("FAIL status_after_reset: v=%b d=%h required 1/0", v, d);
    end
`ifdef UART_TX_DIVISOR_REG_EN
    exp = 32'(CPB);
`else
    exp = 32'h0;
`endif
    bus_read(4'h8, v, d);
    vecs++;
    if (v !== 1'b1 || d !== exp) begin
      errs++;
      $display("FAIL divisor_reset: d=%h required %h", d, exp);
    end
  endtask

  task automatic test_regs();
    logic v;
    logic [31:0] d;
    bus_read(4'h0, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errs++;
      $display("FAIL txdata_reads_zero: v=%b d=%h required 1/0", v, d);
    end
    @(negedge clk);
    vecs++;
    if (read_data_valid !== 1'b0 || read_data !== 32'h0) begin
      errs++;
      $display("FAIL idle_read_bus: rdv=%b rd=%h required 0/0",
               read_data_valid, read_data);
    end
    bus_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    bus_read(4'hC, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errs++;
      $display("FAIL reserved_reads_zero: d=%h required 0", d);
    end
    bus_write(4'h0, 32'h0000_0055, 4'hE);
    repeat (4) @(negedge clk);
    bus_read(4'h5, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errs++;
      $display("FAIL no_push_be0: status=%h required 0", d);
    end
    bus_write(4'h3, 32'h0000_005A, 4'h1);
    wait_drain();
  endtask

  task automatic test_single();
    logic v;
    logic [31:0] d;
    bus_write(4'h0, 32'h0000_00A5, 4'h1);
    vecs++;
    if (tx !== 1'b1) begin
      errs++;
      $display("FAIL start_latency_early: tx=%b required 1", tx);
    end
    @(negedge clk);
    vecs++;
    if (tx !== 1'b0) begin
      errs++;
      $display("FAIL start_latency: tx=%b required 0", tx);
    end
    repeat (39) @(negedge clk);
    bus_read(4'h4, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0000_0001) begin
      errs++;
      $display("FAIL busy_in_stop: status=%h required 00000001", d);
    end
    bus_read(4'h4, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errs++;
      $display("FAIL idle_after_40: status=%h required 00000000", d);
    end
    wait_drain();
  endtask

  task automatic test_status();
    logic v;
    logic [31:0] d;
    bus_write(4'h0, 32'h0000_0011, 4'h1);
    bus_write(4'h0, 32'h0000_0022, 4'h1);
    bus_read(4'h4, v, d);
    // First byte already popped into the shifter; one left queued.
    vecs++;
    if (v !== 1'b1 || d !== {19'b0, 5'd1, 6'b0, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL status_fill: v=%b d=%h required 1/00000101", v, d);
    end
    wait_drain();
  endtask

  task automatic test_rw_same_cycle();
    logic v;
    logic [31:0] d;
    bus_rw(4'h0, 32'h0000_0069, 4'h1, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errs++;
      $display("FAIL rw_txdata: v=%b d=%h required 1/0", v, d);
    end
    bus_read(4'h4, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0000_0101) begin
      errs++;
      $display("FAIL rw_status: d=%h required 00000101", d);
    end
    wait_drain();
`ifdef UART_TX_DIVISOR_REG_EN
    bus_rw(4'h8, 32'h0000_0003, 4'h3, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'(CPB)) begin
      errs++;
      $display("FAIL rw_div_old: d=%h required %h", d, 32'(CPB));
    end
    bus_read(4'h8, v, d);
    vecs++;
    if (d !== 32'h3) begin
      errs++;
      $display("FAIL rw_div_new: d=%h required 3", d);
    end
    bus_write(4'h8, 32'(CPB), 4'h3);
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    bytes = '{8'h01, 8'h80, 8'hFF, 8'h5A, 8'hC3, 8'h3C};
    starts.delete();
    for (int i = 0; i < 5; i++) bus_write(4'h0, 32'(bytes[i]), 4'h1);
    vecs++;
    if (ready !== 1'b0) begin
      errs++;
      $display("FAIL full_ready: ready=%b required 0", ready);
    end
    bus_write(4'h0, 32'(bytes[5]), 4'h1);
    wait_drain();
    vecs++;
    if (starts.size() != 6) begin
      errs++;
      $display("FAIL b2b_count: frames=%0d required 6", starts.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        vecs++;
        if (starts[i] - starts[i-1] != 10 * CPB) begin
          errs++;
          $display("FAIL b2b_gap: spacing=%0d required %0d",
                   starts[i] - starts[i-1], 10 * CPB);
        end
      end
    end
  endtask

  task automatic test_divisor();
    logic v;
    logic [31:0] d;
`ifdef UART_TX_DIVISOR_REG_EN
    starts.delete();
    bus_write(4'h0, 32'h0000_00C6, 4'h1);
    repeat (5) @(negedge clk);
    bus_write(4'h8, 32'h0000_0001, 4'h3);
    bus_read(4'h8, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'h2) begin
      errs++;
      $display("FAIL div_clamp: d=%h required 2", d);
    end
    bus_write(4'h0, 32'h0000_003B, 4'h1);
    wait_drain();
    vecs++;
    if (starts.size() != 2 || starts[1] - starts[0] != 10 * CPB) begin
      errs++;
      $display("FAIL div_frame_unaffected: frames=%0d", starts.size());
    end
    bus_write(4'h8, 32'h0000_ABCD, 4'h2);
    bus_read(4'h8, v, d);
    vecs++;
    if (d !== 32'h0000_AB02) begin
      errs++;
      $display("FAIL div_lane: d=%h required 0000ab02", d);
    end
    bus_write(4'h8, 32'h0000_0000, 4'h3);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mdiv = CPB;
    @(negedge clk);
    bus_read(4'h8, v, d);
    vecs++;
    if (d !== 32'(CPB)) begin
      errs++;
      $display("FAIL div_after_reset: d=%h required %h", d, 32'(CPB));
    end
`else
    bus_write(4'h8, 32'h0000_0001, 4'h3);
    bus_read(4'h8, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errs++;
      $display("FAIL div_fixed: d=%h required 0", d);
    end
    bus_write(4'h0, 32'h0000_00C6, 4'h1);
    wait_drain();
`endif
  endtask

  task automatic test_reset_midframe();
    logic v;
    logic [31:0] d;
    int ones;
    bus_write(4'h0, 32'h0000_0000, 4'h1);
    bus_write(4'h0, 32'h0000_0077, 4'h1);
    repeat (13) @(negedge clk);
    vecs++;
    if (tx !== 1'b0) begin
      errs++;
      $display("FAIL midframe_bit: tx=%b required 0", tx);
    end
    #2;
    mon_abort = 1'b1;
    reset_n = 1'b0;
    #1;
    vecs++;
    if ({tx, ready, read_data_valid} !== 3'b110 || read_data !== 32'h0) begin
      errs++;
      $display("FAIL async_reset: tx/ready/rdv=%b required 110",
               {tx, ready, read_data_valid});
    end
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mdiv = CPB;
    @(negedge clk);
    mon_abort = 1'b0;
    bus_read(4'h4, v, d);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errs++;
      $display("FAIL status_after_abort: d=%h required 0", d);
    end
    ones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx === 1'b1) ones++;
    end
    vecs++;
    if (ones != 80) begin
      errs++;
      $display("FAIL no_tx_after_abort: high_cycles=%0d required 80", ones);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_regs();
    test_single();
    test_status();
    test_rw_same_cycle();
    test_back_to_back();
    test_divisor();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
